// File: rtl/fs_pkg.sv
// Shared types and helpers for the fs subtractor family.
// Holds the default cell width and a word-level golden reference.
package fs_pkg;

  localparam int FS_CELL_DEFAULT_WIDTH = 1;

  // Width of the golden reference. Operands narrower than this are
  // zero-extended by the caller; the borrow is always the top bit.
  localparam int FS_REF_W = 64;

  typedef logic [FS_REF_W:0] fs_ref_t;

  // Golden {bout, d}: the subtraction is done one bit wider than the
  // operands, so the top bit is set exactly when the result is negative.
  function automatic fs_ref_t fs_ref(
    input logic [FS_REF_W-1:0] a,
    input logic [FS_REF_W-1:0] b,
    input logic                bin
  );
    fs_ref = {1'b0, a} - {1'b0, b} - fs_ref_t'(bin);
  endfunction

endpackage

// File: rtl/fs_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
// Ports: a, b, bin (in, 1 bit); d, bout (out, 1 bit).
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b beats a outright, or when a and b tie and a borrow
  // is already coming in from below.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/fs.sv
// WIDTH-bit ripple-borrow subtractor: {borrowout, diff} = a - b - borrowin.
// Ports: clk, rst (used only with REG_OUT=1), a, b, borrowin -> diff, borrowout, zero.
module fs
  import fs_pkg::*;
#(
  parameter int WIDTH   = FS_CELL_DEFAULT_WIDTH,
  parameter bit REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowin,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout,
  output logic             zero
);

  // borrow_chain[i] is the borrow into bit i; the last entry leaves the MSB.
  logic [WIDTH:0]   borrow_chain;
  logic [WIDTH-1:0] diff_comb;
  logic             borrow_comb;
  logic             zero_comb;

  assign borrow_chain[0] = borrowin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fs_bit u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (borrow_chain[i]),
      .d    (diff_comb[i]),
      .bout (borrow_chain[i+1])
    );
  end

  assign borrow_comb = borrow_chain[WIDTH];
  assign zero_comb   = (diff_comb == '0) & ~borrow_comb;

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             zero_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        diff_q   <= '0;
        borrow_q <= 1'b0;
        zero_q   <= 1'b0;
      end else begin
        diff_q   <= diff_comb;
        borrow_q <= borrow_comb;
        zero_q   <= zero_comb;
      end
    end

    assign diff      = diff_q;
    assign borrowout = borrow_q;
    assign zero      = zero_q;
  end else begin : g_comb
    // clk and rst have no function here; they are only sunk so the
    // outputs never depend on them.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign diff      = diff_comb;
    assign borrowout = borrow_comb;
    assign zero      = zero_comb;
  end

endmodule

// File: tb/tb_fs.sv
// Scoreboard bench for fs: stimulus pushes expectations, a monitor
// pops and compares them against four differently configured instances.
module tb_fs;
  import fs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Junk driven onto the clk/rst pins of the "unconnected" instance.
  logic nc_clk = 1'b0;
  logic nc_rst = 1'b0;
  always #3 begin
    nc_clk = 1'($urandom);
    nc_rst = 1'($urandom);
  end

  logic       a1, b1, bi1;
  logic       d1, bo1, z1;
  logic       d1f, bo1f, z1f;
  logic [7:0] a8, b8, d8;
  logic       bi8, bo8, z8;
  logic [7:0] ar, br, dr;
  logic       bir, bor, zr;

  fs u_w1 (
    .clk(clk), .rst(rst),
    .a(a1), .b(b1), .borrowin(bi1),
    .diff(d1), .borrowout(bo1), .zero(z1)
  );

  fs u_w1f (
    .clk(nc_clk), .rst(nc_rst),
    .a(a1), .b(b1), .borrowin(bi1),
    .diff(d1f), .borrowout(bo1f), .zero(z1f)
  );

  fs #(.WIDTH(8), .REG_OUT(1'b0)) u_w8 (
    .clk(clk), .rst(rst),
    .a(a8), .b(b8), .borrowin(bi8),
    .diff(d8), .borrowout(bo8), .zero(z8)
  );

  fs #(.WIDTH(8), .REG_OUT(1'b1)) u_w8r (
    .clk(clk), .rst(rst),
    .a(ar), .b(br), .borrowin(bir),
    .diff(dr), .borrowout(bor), .zero(zr)
  );

  typedef struct {
    int         id;
    string      nm;
    logic [7:0] d;
    logic       bo;
    logic       z;
  } exp_t;

  exp_t q[$];
  event sample;
  int   checks = 0;
  int   passes = 0;

  // Reference: plain integer subtraction, then wrap to w bits.
  function automatic exp_t model(
    input int id, input string nm, input int w,
    input logic [7:0] a, input logic [7:0] b, input logic bin
  );
    exp_t e;
    int   r;
    int   m;
    r = int'(a) - int'(b) - int'(bin);
    m = (1 << w) - 1;
    e.id = id;
    e.nm = nm;
    e.d  = 8'(r & m);
    e.bo = (r < 0);
    e.z  = (r == 0);
    return e;
  endfunction

  function automatic exp_t cst(
    input int id, input string nm,
    input logic [7:0] d, input logic bo, input logic z
  );
    exp_t e;
    e.id = id;
    e.nm = nm;
    e.d  = d;
    e.bo = bo;
    e.z  = z;
    return e;
  endfunction

  task automatic get_act(
    input int id, output logic [7:0] d,
    output logic bo, output logic z
  );
    case (id)
      0: begin d = {7'd0, d1};  bo = bo1;  z = z1;  end
      1: begin d = {7'd0, d1f}; bo = bo1f; z = z1f; end
      2: begin d = d8;          bo = bo8;  z = z8;  end
      default: begin d = dr;    bo = bor;  z = zr;  end
    endcase
  endtask

  // Monitor: one expectation consumed per sample strobe.
  initial begin
    exp_t       e;
    logic [7:0] d;
    logic       bo, z;
    forever begin
      @(sample);
      checks++;
      if (q.size() == 0) begin
        $display("FAIL strobe: no expectation queued");
      end else begin
        e = q.pop_front();
        get_act(e.id, d, bo, z);
        if (d === e.d && bo === e.bo && z === e.z) begin
          passes++;
        end else begin
          $display("FAIL %s: got d=%h bo=%b z=%b want d=%h bo=%b z=%b",
                   e.nm, d, bo, z, e.d, e.bo, e.z);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] v;
    fs_ref_t    r;
    exp_t       e;
    a1 = 0; b1 = 0; bi1 = 0;
    a8 = 0; b8 = 0; bi8 = 0;
    ar = 0; br = 0; bir = 0;

    // Registered instance is in reset from time 0.
    #2;
    q.push_back(cst(3, "reset_state", 8'h00, 1'b0, 1'b0));
    ->sample;
    #1;

    // Exhaustive 1-bit truth table, both clocked and junk-clocked copies.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, bi1} = v;
      q.push_back(model(0, $sformatf("tt%0d", i), 1,
                        {7'd0, v[2]}, {7'd0, v[1]}, v[0]));
      q.push_back(model(1, $sformatf("tt_nc%0d", i), 1,
                        {7'd0, v[2]}, {7'd0, v[1]}, v[0]));
      #5 ->sample;
      #1 ->sample;
      #4;
    end

    // 8-bit combinational boundaries.
    a8 = 8'h00; b8 = 8'h01; bi8 = 1'b0;
    q.push_back(cst(2, "w8_0m1", 8'hFF, 1'b1, 1'b0));
    #5 ->sample; #5;
    a8 = 8'h5A; b8 = 8'h5A; bi8 = 1'b0;
    q.push_back(cst(2, "w8_eq", 8'h00, 1'b0, 1'b1));
    #5 ->sample; #5;
    a8 = 8'h00; b8 = 8'h00; bi8 = 1'b1;
    q.push_back(cst(2, "w8_0m0m1", 8'hFF, 1'b1, 1'b0));
    #5 ->sample; #5;
    a8 = 8'hFF; b8 = 8'h00; bi8 = 1'b0;
    q.push_back(cst(2, "w8_max", 8'hFF, 1'b0, 1'b0));
    #5 ->sample; #5;

    // Random sweep against the package golden function.
    for (int i = 0; i < 1000; i++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      bi8 = 1'($urandom);
      r = fs_ref(64'(a8), 64'(b8), bi8);
      e.id = 2;
      e.nm = "w8_rand";
      e.d  = r[7:0];
      e.bo = r[FS_REF_W];
      e.z  = (r[7:0] == 8'h00) && !r[FS_REF_W];
      q.push_back(e);
      #2 ->sample;
      #1;
    end

    // Registered: release reset between edges, first capture is 0-0-0.
    @(negedge clk);
    #2 rst = 1'b0;
    q.push_back(cst(3, "first_cap", 8'h00, 1'b0, 1'b1));
    @(negedge clk);
    ->sample;

    ar = 8'h80; br = 8'h01; bir = 1'b1;
    q.push_back(cst(3, "hold_pre_edge", 8'h00, 1'b0, 1'b1));
    #1 ->sample;
    q.push_back(cst(3, "lat1", 8'h7E, 1'b0, 1'b0));
    @(negedge clk);
    ->sample;

    // Random registered stream, latency 1.
    ar = 8'($urandom); br = 8'($urandom); bir = 1'($urandom);
    q.push_back(model(3, "reg_rand", 8, ar, br, bir));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ->sample;
      ar = 8'($urandom); br = 8'($urandom); bir = 1'($urandom);
      q.push_back(model(3, "reg_rand", 8, ar, br, bir));
    end
    @(negedge clk);
    ->sample;

    // Mid-stream reset: in-flight value discarded, outputs clear at once.
    ar = 8'h33; br = 8'h11; bir = 1'b0;
    @(posedge clk);
    ar = 8'h10; br = 8'h20; bir = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.push_back(cst(3, "rst_async", 8'h00, 1'b0, 1'b0));
    ->sample;
    @(posedge clk);
    #1;
    q.push_back(cst(3, "rst_hold", 8'h00, 1'b0, 1'b0));
    ->sample;
    @(negedge clk);
    ar = 8'h44; br = 8'h45; bir = 1'b1;
    #2 rst = 1'b0;
    q.push_back(cst(3, "rst_release", 8'hFE, 1'b1, 1'b0));
    @(negedge clk);
    ->sample;

    // Drain with a bound; anything left over is a failure.
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      #1;
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      $display("FAIL %s: never observed, want d=%h bo=%b z=%b",
               e.nm, e.d, e.bo, e.z);
    end

    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
